// File: rtl/fp_normalizer_seq.sv
// fp_normalizer_seq: multi-cycle handshaked floating-point normaliser.
// Accepts an unnormalised sign/exponent/mantissa, right-shifts once on carry-out
// or left-shifts up to STEP positions per cycle until the hidden bit is set, and
// adjusts the exponent. Zero, overflow-to-infinity and denormal results are flagged.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         operand handshake (one operand in flight)
//   in_sign, in_exp, in_mant    operand; in_mant = {carry, hidden, fraction}
//   out_valid / out_ready       result handshake, result held until taken
//   out_sign, out_exp, out_frac normalised result (hidden bit dropped)
//   flag_zero/ovf/unf/inex      zero, overflow, denormal, inexact (carry shift)
module fp_normalizer_seq #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned STEP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              flag_zero,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              flag_inex
);

  localparam int unsigned MANT_W = FRAC_W + 2;
  localparam int unsigned EXPI_W = EXP_W + 1;
  localparam int unsigned LZ_W   = $clog2(FRAC_W + 2) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [EXPI_W-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // Working registers
  logic [1:0]        state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXPI_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              inex_q, inex_d;
  logic              in_ready_q, in_ready_d;

  // Output registers, loaded only when an operation completes
  logic              out_valid_q, out_valid_d;
  logic              out_sign_q, out_sign_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [FRAC_W-1:0] out_frac_q, out_frac_d;
  logic              out_zero_q, out_zero_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_unf_q, out_unf_d;
  logic              out_inex_q, out_inex_d;

  // Completion values computed in NORM
  logic              fin;
  logic [EXP_W-1:0]  fin_exp;
  logic [FRAC_W-1:0] fin_frac;
  logic              fin_zero, fin_ovf, fin_unf, fin_inex;
  logic [EXPI_W-1:0] exp_inc;

  // Leading zeros of the mantissa counted from the hidden-bit position down
  logic [LZ_W-1:0] lz;
  always_comb begin
    lz = LZ_W'(FRAC_W + 1);
    for (int unsigned i = 0; i <= FRAC_W; i++) begin
      if (mant_q[i]) lz = LZ_W'(FRAC_W - i);
    end
  end

  // Left-shift amount for this cycle: min(STEP, lz, exp-1); exp_q >= 2 when used
  logic [31:0] shamt;
  always_comb begin
    shamt = 32'(STEP);
    if (32'(lz) < shamt) shamt = 32'(lz);
    if ((32'(exp_q) - 32'd1) < shamt) shamt = 32'(exp_q) - 32'd1;
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    inex_d      = inex_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    out_inex_d  = out_inex_q;
    fin         = 1'b0;
    fin_exp     = '0;
    fin_frac    = '0;
    fin_zero    = 1'b0;
    fin_ovf     = 1'b0;
    fin_unf     = 1'b0;
    fin_inex    = inex_q;
    exp_inc     = exp_q + EXPI_W'(1);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          // A zero exponent carries the same scale as exponent 1
          exp_d   = (in_exp == '0) ? EXPI_W'(1) : {1'b0, in_exp};
          mant_d  = in_mant;
          inex_d  = 1'b0;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (mant_q == '0) begin
          fin      = 1'b1;
          fin_zero = 1'b1;
        end else if (mant_q[MANT_W-1]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_inc;
          inex_d = inex_q | mant_q[0];
          if (exp_inc >= EXP_MAX) begin
            fin      = 1'b1;
            fin_exp  = {EXP_W{1'b1}};
            fin_ovf  = 1'b1;
            fin_inex = inex_q | mant_q[0];
          end
        end else if (mant_q[FRAC_W]) begin
          fin      = 1'b1;
          fin_exp  = exp_q[EXP_W-1:0];
          fin_frac = mant_q[FRAC_W-1:0];
        end else if (exp_q <= EXPI_W'(1)) begin
          fin      = 1'b1;
          fin_frac = mant_q[FRAC_W-1:0];
          fin_unf  = 1'b1;
        end else begin
          mant_d = mant_q << shamt;
          exp_d  = exp_q - EXPI_W'(shamt);
        end

        if (fin) begin
          out_valid_d = 1'b1;
          out_sign_d  = sign_q;
          out_exp_d   = fin_exp;
          out_frac_d  = fin_frac;
          out_zero_d  = fin_zero;
          out_ovf_d   = fin_ovf;
          out_unf_d   = fin_unf;
          out_inex_d  = fin_inex;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Ready only once the machine is back in IDLE, so no same-cycle re-accept
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      inex_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_inex_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      inex_q      <= inex_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      out_inex_q  <= out_inex_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign flag_zero = out_zero_q;
  assign flag_ovf  = out_ovf_q;
  assign flag_unf  = out_unf_q;
  assign flag_inex = out_inex_q;

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Bench for fp_normalizer_seq: STEP=1 and STEP=4 instances share one operand
// stream; each result and its latency is checked against a scoreboard entry.
module tb_fp_normalizer_seq;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        zero, ovf, unf, inex;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;

  logic [1:0]  in_ready, out_valid, out_sign;
  logic [1:0]  flag_zero, flag_ovf, flag_unf, flag_inex;
  logic [1:0]  out_ready = '0;
  logic [7:0]  out_exp [2];
  logic [22:0] out_frac [2];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   stall_until [2] = '{0, 0};
  exp_t sb_q0 [$];
  exp_t sb_q1 [$];

  always #5 clk = ~clk;

  fp_normalizer_seq #(.EXP_W(8), .FRAC_W(23), .STEP(1)) dut_s1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sign(out_sign[0]), .out_exp(out_exp[0]), .out_frac(out_frac[0]),
    .flag_zero(flag_zero[0]), .flag_ovf(flag_ovf[0]),
    .flag_unf(flag_unf[0]), .flag_inex(flag_inex[0])
  );

  fp_normalizer_seq #(.EXP_W(8), .FRAC_W(23), .STEP(4)) dut_s4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sign(out_sign[1]), .out_exp(out_exp[1]), .out_frac(out_frac[1]),
    .flag_zero(flag_zero[1]), .flag_ovf(flag_ovf[1]),
    .flag_unf(flag_unf[1]), .flag_inex(flag_inex[1])
  );

  function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                              input logic z, input logic o, input logic u, input logic i,
                              input int lat);
    exp_t r;
    r.sign = s; r.exp = e; r.frac = f;
    r.zero = z; r.ovf = o; r.unf = u; r.inex = i;
    r.lat = lat; r.acc = 0;
    return r;
  endfunction

  // Reference: value-level normalisation; latency = shift cycles + final cycle
  function automatic exp_t ref_model(input logic s, input logic [7:0] e_in,
                                     input logic [24:0] m, input int step);
    exp_t        r;
    int          e, lz, sh;
    logic [24:0] mm;
    r = mk(s, 8'h00, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    e = (e_in == 8'h00) ? 1 : int'(e_in);
    if (m == 25'h0) begin
      r.zero = 1'b1;
      return r;
    end
    if (m[24]) begin
      r.inex = m[0];
      e = e + 1;
      if (e >= 255) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
        r.lat = 1;
      end else begin
        mm     = m >> 1;
        r.exp  = 8'(e);
        r.frac = mm[22:0];
        r.lat  = 2;
      end
      return r;
    end
    mm = m;
    lz = 0;
    while (mm[23 - lz] == 1'b0) lz++;
    sh = (lz < e - 1) ? lz : e - 1;
    mm = mm << sh;
    r.frac = mm[22:0];
    r.lat  = (sh + step - 1) / step + 1;
    if (sh == lz) r.exp = 8'(e - lz);
    else          r.unf = 1'b1;
    return r;
  endfunction

  function automatic logic [35:0] pk(input exp_t e);
    return {e.sign, e.exp, e.frac, e.zero, e.ovf, e.unf, e.inex};
  endfunction

  task automatic chk(input bit ok, input string name, input int inst,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %h, want %h", name, inst, cyc, act, req);
    end
  endtask

  // Monitor: reset, hold, busy and result checks, plus random back-pressure
  logic       rst_seen = 1'b0;
  logic       rst_prev = 1'b0;
  logic [1:0] prev_valid = '0;
  logic [1:0] prev_ready = '0;
  logic [35:0] hold [2];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [35:0] act;
      exp_t        e;
      act = {out_sign[i], out_exp[i], out_frac[i],
             flag_zero[i], flag_ovf[i], flag_unf[i], flag_inex[i]};
      if (rst_seen) begin
        chk({out_valid[i], in_ready[i], act} == 38'h0, "reset_state", i,
            64'({out_valid[i], in_ready[i], act}), 64'h0);
      end else begin
        if (rst_prev)
          chk(in_ready[i] == 1'b1, "ready_after_reset", i, 64'(in_ready[i]), 64'h1);
        if (prev_valid[i] && !prev_ready[i])
          chk(out_valid[i] && act == hold[i], "hold_stable", i,
              64'({out_valid[i], act}), 64'({1'b1, hold[i]}));
        if (out_valid[i])
          chk(in_ready[i] == 1'b0, "busy_not_ready", i, 64'(in_ready[i]), 64'h0);
        if (out_valid[i] && !prev_valid[i]) begin
          if (i == 0) chk(sb_q0.size() != 0, "unexpected_result", i, 64'(act), 64'h0);
          else        chk(sb_q1.size() != 0, "unexpected_result", i, 64'(act), 64'h0);
          if ((i == 0 && sb_q0.size() != 0) || (i == 1 && sb_q1.size() != 0)) begin
            e = (i == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            chk(act == pk(e), "result", i, 64'(act), 64'(pk(e)));
            chk(cyc - e.acc == e.lat, "latency", i, 64'(cyc - e.acc), 64'(e.lat));
          end
        end
      end
      hold[i] = act;
      out_ready[i] = (cyc < stall_until[i]) ? 1'b0 : ($urandom_range(0, 3) != 0);
      prev_valid[i] = out_valid[i];
      prev_ready[i] = out_ready[i];
    end
    rst_prev = rst_seen;
  end

  // Wait for both instances idle, present one operand for one edge
  task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m,
                       input bit push, input exp_t x0, input exp_t x1);
    int w;
    w = 0;
    @(posedge clk); #1;
    while (in_ready != 2'b11) begin
      @(posedge clk); #1;
      w++;
      if (w > 3000) begin
        $display("FAIL issue_timeout: in_ready=%b, want 11", in_ready);
        $fatal(1, "driver stuck");
      end
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      x0.acc = cyc;
      x1.acc = cyc;
      sb_q0.push_back(x0);
      sb_q1.push_back(x1);
    end
  endtask

  task automatic issue_rand();
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    int          cls;
    s   = 1'($urandom);
    e   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 254));
    cls = $urandom_range(0, 9);
    if (cls == 0)      m = 25'h0;
    else if (cls <= 3) m = {1'b1, 24'($urandom)};
    else if (cls <= 5) m = {2'b01, 23'($urandom)};
    else               m = {2'b00, 23'($urandom)} >> $urandom_range(0, 22);
    issue(s, e, m, 1'b1, ref_model(s, e, m, 1), ref_model(s, e, m, 4));
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Bit 20 set: three left shifts to normal
    issue(1'b0, 8'hC0, 25'h010_0000, 1'b1,
          mk(1'b0, 8'hBD, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4),
          mk(1'b0, 8'hBD, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2));
    // Carry into an all-ones exponent, LSB dropped
    issue(1'b1, 8'hFE, 25'h180_0001, 1'b1,
          mk(1'b1, 8'hFF, 23'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1),
          mk(1'b1, 8'hFF, 23'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1));
    // Exponent runs out before the hidden bit: denormal
    issue(1'b0, 8'h02, 25'h010_0000, 1'b1,
          mk(1'b0, 8'h00, 23'h20_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2),
          mk(1'b0, 8'h00, 23'h20_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2));
    // Carry without overflow, exact
    issue(1'b0, 8'h10, 25'h100_0002, 1'b1,
          mk(1'b0, 8'h11, 23'h00_0001, 1'b0, 1'b0, 1'b0, 1'b0, 2),
          mk(1'b0, 8'h11, 23'h00_0001, 1'b0, 1'b0, 1'b0, 1'b0, 2));
    // Zero with downstream stalled for several cycles
    stall_until[0] = cyc + 10;
    stall_until[1] = cyc + 10;
    issue(1'b1, 8'h5A, 25'h0, 1'b1,
          mk(1'b1, 8'h00, 23'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1),
          mk(1'b1, 8'h00, 23'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    // Long normalisation aborted by reset: no result may appear
    issue(1'b0, 8'hC0, 25'h000_0001, 1'b0,
          mk(1'b0, 8'h00, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0),
          mk(1'b0, 8'h00, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 400; k++) issue_rand();

    w = 0;
    while ((sb_q0.size() != 0 || sb_q1.size() != 0 || out_valid != 2'b00) && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 5000) begin
      $display("FAIL drain_timeout: pending %0d/%0d results, want 0/0", sb_q0.size(), sb_q1.size());
      $fatal(1, "drain stuck");
    end
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
